// File: rtl/insn_queue_mw.sv
// Multi-wide instruction queue between fetch and dispatch: all-or-nothing group
// enqueue of up to IN_W entries, prefix dequeue of up to OUT_W oldest entries.
module insn_queue_mw #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 64,
    parameter int IN_W   = 2,
    parameter int OUT_W  = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash_in,
    input  logic [$clog2(IN_W+1)-1:0]  in_count,
    input  logic [IN_W*DATA_W-1:0]     in_data,
    output logic                       in_accept,
    input  logic [$clog2(OUT_W+1)-1:0] deq_count,
    output logic [OUT_W*DATA_W-1:0]    out_data,
    output logic [$clog2(OUT_W+1)-1:0] out_avail,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [$clog2(DEPTH+1)-1:0] free_slots,
    output logic                       full,
    output logic                       empty,
    output logic                       deq_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int IC_W  = $clog2(IN_W + 1);
    localparam int OC_W  = $clog2(OUT_W + 1);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int EXT_W = CNT_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [OC_W-1:0]   deq_eff;
    logic [EXT_W-1:0]  count_ext, enq_ext, deq_ext;

    // Status and handshake are combinational from state and current inputs only.
    always_comb begin
        count      = count_q;
        free_slots = CNT_W'(DEPTH) - count_q;
        full       = (count_q == CNT_W'(DEPTH));
        empty      = (count_q == '0);
        out_avail  = (count_q >= CNT_W'(OUT_W)) ? OC_W'(OUT_W) : OC_W'(count_q);
        // Slots freed by a same-cycle dequeue are deliberately not credited.
        in_accept  = !squash_in && (in_count != '0) &&
                     (EXT_W'(in_count) <= EXT_W'(free_slots));
        deq_err    = (deq_count > out_avail);
        deq_eff    = deq_err ? out_avail : deq_count;
    end

    always_comb begin
        out_data = '0;
        for (int j = 0; j < OUT_W; j++) begin
            if (OC_W'(j) < out_avail)
                out_data[j*DATA_W +: DATA_W] = mem_q[head_q + PTR_W'(j)];
        end
    end

    always_comb begin
        count_ext = EXT_W'(count_q);
        enq_ext   = in_accept ? EXT_W'(in_count) : '0;
        deq_ext   = EXT_W'(deq_eff);
        count_d   = CNT_W'(count_ext + enq_ext - deq_ext);
        head_d    = head_q + PTR_W'(deq_eff);
        tail_d    = tail_q + (in_accept ? PTR_W'(in_count) : '0);

        mem_d = mem_q;
        if (in_accept) begin
            for (int i = 0; i < IN_W; i++) begin
                if (IC_W'(i) < in_count)
                    mem_d[tail_q + PTR_W'(i)] = in_data[i*DATA_W +: DATA_W];
            end
        end

        // Squash only resets the window; storage is left as-is except on reset.
        if (reset || squash_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
        if (reset) begin
            for (int k = 0; k < DEPTH; k++)
                mem_d[k] = '0;
        end
    end

    always_ff @(posedge clock) begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        mem_q   <= mem_d;
    end

endmodule

// File: tb/tb_insn_queue_mw.sv
// Bench for insn_queue_mw: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_insn_queue_mw;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 64;
    localparam int IN_W   = 2;
    localparam int OUT_W  = 2;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                squash_in = 1'b0;
    logic [1:0]          in_count = '0;
    logic [2*DATA_W-1:0] in_data = '0;
    logic                in_accept;
    logic [1:0]          deq_count = '0;
    logic [2*DATA_W-1:0] out_data;
    logic [1:0]          out_avail;
    logic [4:0]          count;
    logic [4:0]          free_slots;
    logic                full, empty, deq_err;

    int checks = 0;
    int failures = 0;

    insn_queue_mw #(.DEPTH(DEPTH), .DATA_W(DATA_W), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clock(clock), .reset(reset), .squash_in(squash_in),
        .in_count(in_count), .in_data(in_data), .in_accept(in_accept),
        .deq_count(deq_count), .out_data(out_data), .out_avail(out_avail),
        .count(count), .free_slots(free_slots), .full(full), .empty(empty),
        .deq_err(deq_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] tag(input logic [7:0] grp, input int k);
        return {grp, 48'h0, 8'(k)};
    endfunction

    // Reference model: the queue holds the valid entries, oldest first.
    logic [63:0] mq[$];
    bit          mvalid = 0;

    always @(negedge clock) begin
        int          cnt, avail, free_n, ic, dc, eff;
        bit          acc;
        logic [63:0] lane;
        if (reset) begin
            mq.delete();
            mvalid = 1;
        end else if (mvalid) begin
            cnt    = mq.size();
            avail  = (cnt < OUT_W) ? cnt : OUT_W;
            free_n = DEPTH - cnt;
            ic     = int'(in_count);
            dc     = int'(deq_count);
            acc    = !squash_in && ic != 0 && ic <= free_n;
            chk("m_count", 64'(count), 64'(cnt));
            chk("m_free_slots", 64'(free_slots), 64'(free_n));
            chk("m_full", 64'(full), 64'(cnt == DEPTH));
            chk("m_empty", 64'(empty), 64'(cnt == 0));
            chk("m_out_avail", 64'(out_avail), 64'(avail));
            chk("m_in_accept", 64'(in_accept), 64'(acc));
            chk("m_deq_err", 64'(deq_err), 64'(dc > avail));
            for (int j = 0; j < OUT_W; j++) begin
                lane = (j < avail) ? mq[j] : 64'h0;
                chk($sformatf("m_out_data%0d", j), out_data[j*DATA_W +: DATA_W], lane);
            end
            eff = (dc > avail) ? avail : dc;
            if (squash_in) begin
                mq.delete();
            end else begin
                repeat (eff) void'(mq.pop_front());
                if (acc)
                    for (int i = 0; i < ic; i++) mq.push_back(in_data[i*DATA_W +: DATA_W]);
            end
        end
    end

    task automatic drive(input int ic, input logic [63:0] d0, input logic [63:0] d1,
                         input int dc, input logic sq);
        @(posedge clock);
        #1;
        in_count  = 2'(ic);
        in_data   = {d1, d0};
        deq_count = 2'(dc);
        squash_in = sq;
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        in_count = '0; deq_count = '0; squash_in = 1'b0; in_data = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        do_reset();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_free", 64'(free_slots), 64'd16);
        chk("rst_avail", 64'(out_avail), 64'd0);
        chk("rst_out_data", 64'(out_data != '0), 64'd0);

        // Fill with eight pairs, then a ninth group must be rejected.
        for (int k = 0; k < 8; k++) begin
            drive(2, tag(8'hA0, 2*k), tag(8'hA0, 2*k+1), 0, 0);
            chk("fill_accept", 64'(in_accept), 64'd1);
        end
        drive(2, tag(8'hA0, 16), tag(8'hA0, 17), 0, 0);
        chk("full_flag", 64'(full), 64'd1);
        chk("full_count", 64'(count), 64'd16);
        chk("full_reject", 64'(in_accept), 64'd0);
        drive(2, tag(8'hA0, 16), tag(8'hA0, 17), 2, 0);
        chk("full_deq_reject", 64'(in_accept), 64'd0);
        chk("full_lane0", out_data[63:0], tag(8'hA0, 0));
        chk("full_lane1", out_data[127:64], tag(8'hA0, 1));
        drive(2, tag(8'hA0, 16), tag(8'hA0, 17), 0, 0);
        chk("after_deq_count", 64'(count), 64'd14);
        chk("after_deq_accept", 64'(in_accept), 64'd1);
        chk("after_deq_lane0", out_data[63:0], tag(8'hA0, 2));
        drive(0, 64'h0, 64'h0, 0, 0);
        chk("refill_count", 64'(count), 64'd16);

        // Move head/tail to index 14, then write and read across the 15->0 wrap.
        do_reset();
        for (int k = 0; k < 7; k++) drive(2, tag(8'hD0, 2*k), tag(8'hD0, 2*k+1), 0, 0);
        for (int k = 0; k < 7; k++) drive(0, 64'h0, 64'h0, 2, 0);
        drive(1, tag(8'hC0, 0), 64'h0, 0, 0);
        chk("wrap_empty", 64'(empty), 64'd1);
        drive(2, tag(8'hC0, 1), tag(8'hC0, 2), 0, 0);
        chk("wrap_single_lane0", out_data[63:0], tag(8'hC0, 0));
        chk("wrap_single_lane1", out_data[127:64], 64'h0);
        drive(1, tag(8'hC0, 3), 64'h0, 1, 0);
        chk("wrap_lane0", out_data[63:0], tag(8'hC0, 0));
        chk("wrap_lane1", out_data[127:64], tag(8'hC0, 1));
        drive(0, 64'h0, 64'h0, 2, 0);
        chk("wrap_span_lane0", out_data[63:0], tag(8'hC0, 1));
        chk("wrap_span_lane1", out_data[127:64], tag(8'hC0, 2));
        chk("wrap_count", 64'(count), 64'd3);

        // Over-request with one entry left: clamped dequeue plus error pulse.
        drive(0, 64'h0, 64'h0, 2, 0);
        chk("over_count", 64'(count), 64'd1);
        chk("over_err", 64'(deq_err), 64'd1);
        chk("over_lane0", out_data[63:0], tag(8'hC0, 3));
        drive(0, 64'h0, 64'h0, 0, 0);
        chk("over_after_count", 64'(count), 64'd0);
        chk("over_after_empty", 64'(empty), 64'd1);
        chk("over_after_err", 64'(deq_err), 64'd0);

        // Squash with traffic offered on both sides.
        for (int k = 0; k < 3; k++) drive(2, tag(8'hE0, 2*k), tag(8'hE0, 2*k+1), 0, 0);
        drive(2, tag(8'hE0, 6), tag(8'hE0, 7), 2, 1);
        chk("sq_count_before", 64'(count), 64'd6);
        chk("sq_accept", 64'(in_accept), 64'd0);
        chk("sq_err", 64'(deq_err), 64'd0);
        drive(0, 64'h0, 64'h0, 1, 1);
        chk("sq_count_after", 64'(count), 64'd0);
        chk("sq_avail_after", 64'(out_avail), 64'd0);
        chk("sq_err_ungated", 64'(deq_err), 64'd1);
        drive(2, tag(8'hB0, 0), tag(8'hB0, 1), 0, 0);
        chk("post_sq_accept", 64'(in_accept), 64'd1);
        chk("post_sq_empty", 64'(empty), 64'd1);
        drive(0, 64'h0, 64'h0, 0, 0);
        chk("post_sq_lane0", out_data[63:0], tag(8'hB0, 0));
        chk("post_sq_lane1", out_data[127:64], tag(8'hB0, 1));
        chk("post_sq_avail", 64'(out_avail), 64'd2);

        drive(0, 64'h0, 64'h0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/insn_queue_mw.md
# insn_queue_mw

Parametrised, multi-wide successor to the single-entry instruction buffer, sitting between fetch and dispatch. It accepts up to IN_W instructions per cycle from fetch as an all-or-nothing group and presents up to OUT_W oldest entries per cycle to dispatch. Dispatch may consume any prefix of those entries. A squash empties the queue in one cycle, and occupancy, free-slot and error outputs are exported for fetch throttling and debug.

## Interface
- DEPTH, 16: entry count; power of two, ≥ max(IN_W, OUT_W), ≥ 4
- DATA_W, 64: bits per entry (opaque instruction packet)
- IN_W, 2: enqueue lanes per cycle
- OUT_W, 2: dequeue lanes per cycle
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- squash_in  in  1  flush all entries
- in_count  in  $clog2(IN_W+1)  valid enqueue lanes; lanes 0..in_count-1 are valid, oldest in lane 0
- in_data  in  IN_W*DATA_W  enqueue payload; lane i at bits [i*DATA_W +: DATA_W]
- in_accept  out  1  the offered group is written this cycle
- deq_count  in  $clog2(OUT_W+1)  entries dispatch takes this cycle (lanes 0..deq_count-1)
- out_data  out  OUT_W*DATA_W  oldest entries; lane 0 = head
- out_avail  out  $clog2(OUT_W+1)  min(count, OUT_W)
- count  out  $clog2(DEPTH+1)  current occupancy
- free_slots  out  $clog2(DEPTH+1)  DEPTH − count
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- deq_err  out  1  one-cycle pulse: deq_count > out_avail this cycle (not gated by squash)

## Operation
- Storage: DEPTH×DATA_W circular array. head and tail pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is held in a separate count register, so full and empty are unambiguous.
- Enqueue: in_accept = !squash_in && in_count != 0 && in_count ≤ free_slots.
  - free_slots is the pre-edge value; slots freed by a same-cycle dequeue are not credited.
  - The group is all-or-nothing. A rejected group is not written, and fetch holds and re-offers it.
  - On accept, lane i is written to entry (tail+i) mod DEPTH, and tail advances by in_count.
- Dequeue: deq_eff = min(deq_count, out_avail); out-of-range requests are clamped. deq_err = (deq_count > out_avail).
  - head advances by deq_eff modulo DEPTH.
  - Dequeued entries are not cleared.
- Count update: count_next = count + (in_accept ? in_count : 0) − deq_eff. Compute at $clog2(DEPTH+1)+1 bits. Overflow and underflow are impossible by construction.
- out_data lane j = entry (head+j) mod DEPTH for j < out_avail, otherwise all zeros. This is combinational from registers; there is no input-to-output path.
- Squash: head, tail and count are forced to 0 and enqueue/dequeue are ignored that cycle. Storage contents are not cleared; the valid window is defined by count.
- Reset: same as squash, and additionally the storage is zeroed.

## Timing
- Outputs after reset: in_accept per inputs (0 if in_count = 0), out_avail 0, count 0, free_slots DEPTH, full 0, empty 1, out_data all zeros, deq_err per inputs.
- Enqueue-to-visible latency is 1 cycle: an entry accepted at edge N appears on out_data after edge N. There is no bypass to the output in the same cycle.
- in_accept, out_avail, out_data and deq_err are combinational from the current state and inputs. All state updates on the rising edge.
- Simultaneous enqueue and dequeue are both applied, and count nets the two. When full, a same-cycle dequeue still does not permit an enqueue.
- Wrap-around: multi-lane writes and reads that span index DEPTH−1→0 are contiguous modulo DEPTH.
- Priority: reset > squash_in > normal operation. A squash asserted mid-burst empties the queue at that edge; the next cycle accepts fresh groups normally.

## Test plan
- Reset then idle, defaults (DEPTH 16, IN_W 2, OUT_W 2) → count 0, empty 1, free_slots 16, out_avail 0, out_data 0.
- Enqueue 8 groups of 2 (A0..A15), deq_count 0 → in_accept 1 ×8, then full 1. A 9th group is rejected (in_accept 0) and count stays 16.
- From full, deq_count 2 while offering 2 → in_accept 0, count 14. Next cycle the offer is accepted and count returns to 16.
- Fill 14, drain 14 in pairs, then enqueue 4 → writes wrap across index 15→0, and out_data shows correct order across the wrap.
- count 1, deq_count 2 → deq_err 1, deq_eff 1, count 0, empty 1.
- count 6, squash_in with in_count 2 and deq_count 2 → next cycle count 0, empty 1, out_avail 0. A following enqueue of B0, B1 appears on lanes 0 and 1 after one cycle.
